idmt_trip_logic: RTL and testbench

//  Inverse-time overcurrent (IDMT-style) trip element plus a definite-time instantaneous element.

---
 rtl/relay_pkg.sv | 22 ++
 rtl/idmt_band_rate.sv | 62 ++++++
 rtl/idmt_trip_logic.sv | 121 ++++++++++++
 tb/tb_idmt_trip_logic.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/relay_pkg.sv
// Shared definitions for the protection-relay stages.
//   idmt_state_e : trip FSM encodings (IDLE/TIMING/DECAY/TRIPPED)
//   ACC_W        : accumulator width shared with the other relay stages
//   INC_*        : per-sample accumulator increments for each current band
package relay_pkg;

    localparam int ACC_W = 16;
    localparam int INC_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TIMING  = 2'd1,
        ST_DECAY   = 2'd2,
        ST_TRIPPED = 2'd3
    } idmt_state_e;

    localparam logic [INC_W-1:0] INC_1X = 7'd1;
    localparam logic [INC_W-1:0] INC_2X = 7'd4;
    localparam logic [INC_W-1:0] INC_4X = 7'd16;
    localparam logic [INC_W-1:0] INC_8X = 7'd64;

endpackage

// File: rtl/idmt_band_rate.sv
// Band classification of the RMS current.
//   clk_i        : sample clock
//   rst_i        : synchronous active-high reset
//   i_rms_i      : unsigned RMS magnitude
//   inc_o        : accumulator increment for the current band (0/1/4/16/64)
//   ge_pickup_o  : i_rms_i >= PICKUP
//   ge_dropout_o : i_rms_i >= DROPOUT
//   ge_inst_o    : i_rms_i >= INST_PICKUP
//   pickup_o     : registered ge_pickup_o
// The compare flags and increment are consumed by the trip FSM on the same
// edge that samples the current, so the trip latency counts from the
// qualifying sample itself; only the pickup indication is a flop here.
module idmt_band_rate
    import relay_pkg::*;
#(
    parameter int PICKUP      = 1000,
    parameter int DROPOUT     = 950,
    parameter int INST_PICKUP = 10000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [15:0]      i_rms_i,
    output logic [INC_W-1:0] inc_o,
    output logic             ge_pickup_o,
    output logic             ge_dropout_o,
    output logic             ge_inst_o,
    output logic             pickup_o
);

    // 19-bit compares so 8*PICKUP cannot wrap for any legal parameter value.
    localparam logic [18:0] TH_1X   = 19'(PICKUP);
    localparam logic [18:0] TH_2X   = 19'(2 * PICKUP);
    localparam logic [18:0] TH_4X   = 19'(4 * PICKUP);
    localparam logic [18:0] TH_8X   = 19'(8 * PICKUP);
    localparam logic [18:0] TH_DROP = 19'(DROPOUT);
    localparam logic [18:0] TH_INST = 19'(INST_PICKUP);

    logic [18:0] i_ext;
    logic        pickup_q;

    assign i_ext = {3'b000, i_rms_i};

    always_comb begin
        inc_o = '0;
        if (i_ext >= TH_8X)      inc_o = INC_8X;
        else if (i_ext >= TH_4X) inc_o = INC_4X;
        else if (i_ext >= TH_2X) inc_o = INC_2X;
        else if (i_ext >= TH_1X) inc_o = INC_1X;
    end

    assign ge_pickup_o  = (i_ext >= TH_1X);
    assign ge_dropout_o = (i_ext >= TH_DROP);
    assign ge_inst_o    = (i_ext >= TH_INST);

    always_ff @(posedge clk_i) begin
        if (rst_i) pickup_q <= 1'b0;
        else       pickup_q <= ge_pickup_o;
    end

    assign pickup_o = pickup_q;

endmodule

// File: rtl/idmt_trip_logic.sv
// Inverse-time overcurrent trip element plus definite-time instantaneous
// element, with a trip output latched until acknowledged.
//   clk_800hz : sample clock, one rising edge per I_rms sample
//   reset     : synchronous active-high reset
//   I_rms     : unsigned RMS magnitude
//   trip_ack  : level request to clear a latched trip (needs I_rms < DROPOUT)
//   pickup    : registered I_rms >= PICKUP
//   trip      : latched trip command
//   trip_inst : set with trip when the instantaneous element caused it
//   accum     : inverse-time accumulator (diagnostic)
//   state     : FSM state (diagnostic)
// The accumulator models an induction disc: it advances at a band-dependent
// rate above pickup, holds in the hysteresis band, and winds back linearly
// below dropout.
module idmt_trip_logic
    import relay_pkg::*;
#(
    parameter int PICKUP      = 1000,
    parameter int DROPOUT     = 950,
    parameter int TRIP_COUNT  = 800,
    parameter int DECAY_STEP  = 4,
    parameter int INST_PICKUP = 10000,
    parameter int INST_CYCLES = 8
) (
    input  logic             clk_800hz,
    input  logic             reset,
    input  logic [15:0]      I_rms,
    input  logic             trip_ack,
    output logic             pickup,
    output logic             trip,
    output logic             trip_inst,
    output logic [ACC_W-1:0] accum,
    output logic [1:0]       state
);

    localparam int CNT_W = $clog2(INST_CYCLES + 1);
    localparam logic [ACC_W-1:0] TRIP_TH  = ACC_W'(TRIP_COUNT);
    localparam logic [ACC_W-1:0] DEC_STEP = ACC_W'(DECAY_STEP);
    localparam logic [CNT_W-1:0] INST_TH  = CNT_W'(INST_CYCLES);

    logic [INC_W-1:0] inc;
    logic             ge_pickup, ge_dropout, ge_inst;

    idmt_state_e      state_q;
    logic [ACC_W-1:0] accum_q;
    logic             trip_q, trip_inst_q;
    logic [CNT_W-1:0] inst_cnt_q, inst_cnt_d;

    logic [ACC_W:0]   acc_sum;
    logic [ACC_W-1:0] acc_sat_d, acc_dec_d;
    logic             idmt_fire, inst_fire;

    idmt_band_rate #(
        .PICKUP      (PICKUP),
        .DROPOUT     (DROPOUT),
        .INST_PICKUP (INST_PICKUP)
    ) u_band (
        .clk_i        (clk_800hz),
        .rst_i        (reset),
        .i_rms_i      (I_rms),
        .inc_o        (inc),
        .ge_pickup_o  (ge_pickup),
        .ge_dropout_o (ge_dropout),
        .ge_inst_o    (ge_inst),
        .pickup_o     (pickup)
    );

    always_comb begin
        acc_sum    = {1'b0, accum_q} + (ACC_W + 1)'(inc);
        acc_sat_d  = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
        acc_dec_d  = (accum_q > DEC_STEP) ? (accum_q - DEC_STEP) : '0;
        inst_cnt_d = ge_inst ? (inst_cnt_q + 1'b1) : '0;
        inst_fire  = ge_inst && (inst_cnt_d >= INST_TH);
        idmt_fire  = ge_pickup && (acc_sat_d >= TRIP_TH);
    end

    always_ff @(posedge clk_800hz) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            accum_q     <= '0;
            trip_q      <= 1'b0;
            trip_inst_q <= 1'b0;
            inst_cnt_q  <= '0;
        end else begin
            case (state_q)
                ST_TRIPPED: begin
                    // Everything frozen until acknowledged with current below dropout.
                    if (trip_ack && !ge_dropout) begin
                        state_q     <= ST_IDLE;
                        accum_q     <= '0;
                        trip_q      <= 1'b0;
                        trip_inst_q <= 1'b0;
                        inst_cnt_q  <= '0;
                    end
                end
                default: begin
                    inst_cnt_q <= inst_cnt_d;
                    if (ge_pickup) begin
                        accum_q <= acc_sat_d;
                        state_q <= ST_TIMING;
                    end else if (!ge_dropout) begin
                        accum_q <= acc_dec_d;
                        state_q <= (acc_dec_d != '0) ? ST_DECAY : ST_IDLE;
                    end
                    // Hysteresis band: accumulator and state simply hold.
                    if (idmt_fire || inst_fire) begin
                        trip_q      <= 1'b1;
                        trip_inst_q <= inst_fire;
                        state_q     <= ST_TRIPPED;
                    end
                end
            endcase
        end
    end

    assign trip      = trip_q;
    assign trip_inst = trip_inst_q;
    assign accum     = accum_q;
    assign state     = state_q;

endmodule

// File: tb/tb_idmt_trip_logic.sv
module tb_idmt_trip_logic;

    logic        clk_800hz = 1'b0;
    logic        reset     = 1'b1;
    logic [15:0] I_rms     = '0;
    logic        trip_ack  = 1'b0;
    logic        pickup, trip, trip_inst;
    logic [15:0] accum;
    logic [1:0]  state;

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [1:0] S_IDLE = 2'd0, S_TIMING = 2'd1, S_DECAY = 2'd2, S_TRIPPED = 2'd3;

    idmt_trip_logic dut (
        .clk_800hz (clk_800hz),
        .reset     (reset),
        .I_rms     (I_rms),
        .trip_ack  (trip_ack),
        .pickup    (pickup),
        .trip      (trip),
        .trip_inst (trip_inst),
        .accum     (accum),
        .state     (state)
    );

    always #5 clk_800hz = ~clk_800hz;

    // Apply inputs, take n rising edges, then settle 1 time unit past the edge.
    task automatic run(input logic [15:0] val, input logic ack, input int n);
        I_rms    = val;
        trip_ack = ack;
        for (int k = 0; k < n; k++) begin
            @(posedge clk_800hz);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Clear a latched trip with ack and zero current.
    task automatic clear_trip();
        run(16'd0, 1'b1, 1);
        trip_ack = 1'b0;
    endtask

    initial begin
        // Reset
        reset = 1'b1;
        run(16'd1414, 1'b0, 2);
        check("rst_pickup", 32'(pickup), 0);
        check("rst_trip", 32'(trip), 0);
        check("rst_accum", 32'(accum), 0);
        check("rst_state", 32'(state), S_IDLE);
        reset = 1'b0;

        // Hysteresis edges from IDLE: 999 holds, 1000 picks up
        run(16'd999, 1'b0, 1);
        check("b999_pickup", 32'(pickup), 0);
        check("b999_state", 32'(state), S_IDLE);
        run(16'd0, 1'b0, 1);

        // 1x band: trip on edge 800
        run(16'd1414, 1'b0, 1);
        check("s1_e1_pickup", 32'(pickup), 1);
        check("s1_e1_accum", 32'(accum), 1);
        check("s1_e1_state", 32'(state), S_TIMING);
        run(16'd1414, 1'b0, 798);
        check("s1_e799_trip", 32'(trip), 0);
        check("s1_e799_accum", 32'(accum), 799);
        run(16'd1414, 1'b0, 1);
        check("s1_e800_trip", 32'(trip), 1);
        check("s1_e800_inst", 32'(trip_inst), 0);
        check("s1_e800_accum", 32'(accum), 800);
        check("s1_e800_state", 32'(state), S_TRIPPED);

        // Ack ignored while current above dropout; accum frozen, pickup still tracks
        run(16'd1414, 1'b1, 3);
        check("s5_ack_hi_trip", 32'(trip), 1);
        check("s5_ack_hi_accum", 32'(accum), 800);
        check("s5_ack_hi_pickup", 32'(pickup), 1);
        run(16'd0, 1'b1, 1);
        check("s5_clr_trip", 32'(trip), 0);
        check("s5_clr_accum", 32'(accum), 0);
        check("s5_clr_state", 32'(state), S_IDLE);
        check("s5_clr_pickup", 32'(pickup), 0);
        trip_ack = 1'b0;

        // 2x band: trip on edge 200
        run(16'd2500, 1'b0, 199);
        check("s2a_e199_trip", 32'(trip), 0);
        check("s2a_e199_accum", 32'(accum), 796);
        run(16'd2500, 1'b0, 1);
        check("s2a_e200_trip", 32'(trip), 1);
        clear_trip();

        // 8x band: trip on edge 13
        run(16'd8000, 1'b0, 12);
        check("s2b_e12_trip", 32'(trip), 0);
        check("s2b_e12_accum", 32'(accum), 768);
        run(16'd8000, 1'b0, 1);
        check("s2b_e13_trip", 32'(trip), 1);
        check("s2b_e13_accum", 32'(accum), 832);
        check("s2b_e13_inst", 32'(trip_inst), 0);
        clear_trip();

        // Instantaneous: trip on edge 8
        run(16'd12000, 1'b0, 7);
        check("s3a_e7_trip", 32'(trip), 0);
        run(16'd12000, 1'b0, 1);
        check("s3a_e8_trip", 32'(trip), 1);
        check("s3a_e8_inst", 32'(trip_inst), 1);
        check("s3a_e8_accum", 32'(accum), 512);
        check("s3a_e8_state", 32'(state), S_TRIPPED);
        clear_trip();
        check("s3a_clr_inst", 32'(trip_inst), 0);

        // Instantaneous counter restarts after a 9000 sample; IDMT trips at edge 13
        run(16'd12000, 1'b0, 7);
        run(16'd9000, 1'b0, 1);
        run(16'd12000, 1'b0, 4);
        check("s3b_e12_trip", 32'(trip), 0);
        run(16'd12000, 1'b0, 1);
        check("s3b_e13_trip", 32'(trip), 1);
        check("s3b_e13_inst", 32'(trip_inst), 0);
        clear_trip();

        // Decay and hysteresis hold
        run(16'd1414, 1'b0, 400);
        check("s4_e400_accum", 32'(accum), 400);
        run(16'd900, 1'b0, 50);
        check("s4_decay_accum", 32'(accum), 200);
        check("s4_decay_state", 32'(state), S_DECAY);
        run(16'd1414, 1'b0, 1);
        check("s4_resume_accum", 32'(accum), 201);
        run(16'd970, 1'b0, 100);
        check("s4_hold_accum", 32'(accum), 201);
        check("s4_hold_state", 32'(state), S_TIMING);
        check("s4_hold_pickup", 32'(pickup), 0);
        run(16'd1414, 1'b0, 598);
        check("s4_pre_trip", 32'(trip), 0);
        run(16'd1414, 1'b0, 1);
        check("s4_trip", 32'(trip), 1);
        clear_trip();

        // Decay floors at 0 and returns to IDLE; ack outside TRIPPED is inert
        run(16'd1414, 1'b0, 3);
        run(16'd0, 1'b1, 1);
        check("dec_floor_accum", 32'(accum), 0);
        check("dec_floor_state", 32'(state), S_IDLE);
        run(16'd1414, 1'b1, 2);
        check("ack_idle_accum", 32'(accum), 2);
        check("ack_idle_trip", 32'(trip), 0);
        run(16'd0, 1'b0, 1);

        // Reset mid-timing at edge 500
        run(16'd1414, 1'b0, 499);
        reset = 1'b1;
        run(16'd1414, 1'b0, 1);
        check("s6_rst_pickup", 32'(pickup), 0);
        check("s6_rst_accum", 32'(accum), 0);
        check("s6_rst_state", 32'(state), S_IDLE);
        reset = 1'b0;
        run(16'd1414, 1'b0, 799);
        check("s6_e799_trip", 32'(trip), 0);
        run(16'd1414, 1'b0, 1);
        check("s6_e800_trip", 32'(trip), 1);
        check("s6_e800_accum", 32'(accum), 800);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
